exec_unit: RTL
==============

// Module: exec_unit
// PURPOSE
//  Parametrised, registered integer execution unit fed by the reservation station; drives the CDB (rob/rs/lsq) and the ROB jump path.
//  Successor to the combinational ALU: valid/ready handshakes on both sides, a registered result held until the CDB grants,
//  correct branch/JALR target computation, flush, and an optional iterative multiplier.
// PARAMETERS
//  XLEN       32  data width (power of 2, >=8)
//  TAG_W      4   ROB tag width
//  OP_W       6   operation code width (opcode values from shared package)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  flush        in   1        misprediction flush; kills accepted/pending work
//  in_valid     in   1        RS issues an op this cycle
//  in_ready     out  1        unit can accept this cycle
//  op           in   OP_W     operation
//  in_rob_tag   in   TAG_W    destination ROB tag
//  pc           in   XLEN     instruction PC
//  a, b         in   XLEN     operands rs1/rs2
//  imm          in   XLEN     sign-extended immediate (LUI: already <<12 by decoder)
//  out_valid    out  1        result on CDB valid
//  out_ready    in   1        CDB grant; result retires when out_valid&&out_ready
//  out_data     out  XLEN     result / load-store address / branch taken flag
//  out_rob_tag  out  TAG_W    tag of result
//  out_ls_data  out  XLEN     b captured at issue (store data)
//  jump_ena     out  1        redirect valid (qualified by out_valid)
//  jump_addr    out  XLEN     redirect target
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, in_ready=1 after reset deassert.
//  States: IDLE (no result), BUSY (multiplier iterating), RESULT (out_valid=1, awaiting out_ready).
//  in_ready = (state==IDLE) | (state==RESULT & out_ready); accept = in_valid & in_ready & ~flush.
//  Single-cycle ops: accept in cycle N -> out_valid, out_* registered in N+1 (latency 1); back-to-back accepts give one result/cycle.
//  RESULT holds every output stable while ~out_ready; retire without new accept -> IDLE.
//  Arithmetic: modulo 2^XLEN; shifts use low $clog2(XLEN) bits of b/imm; SRA/SRAI arithmetic; SLT*/branch flags zero-extended 0/1.
//  LUI: out=imm. AUIPC: pc+imm. JAL: out=pc+4, jump_ena=0. JALR: out=pc+4, jump_addr=(a+imm)&~1, jump_ena=1.
//  Branches: out=taken, jump_ena=taken, jump_addr = taken ? pc+imm : pc+4.
//  Loads/stores: out=a+imm, out_ls_data=b, jump_ena=0. Undefined op: out=0, jump_ena=0, still completes with its tag.
//  flush: next state IDLE, out_valid=0, multiplier aborted; flush wins over simultaneous in_valid (input dropped) and out_ready.
//  jump_ena/jump_addr are 0 whenever out_valid=0.
// CONFIGURATION
//  EXEC_MUL_EN defined: MUL, MULH, MULHSU, MULHU accepted; radix-2 shift-add over XLEN cycles in BUSY,
//   result out_valid exactly XLEN+1 cycles after accept; in_ready=0 in BUSY; signed forms via sign-correction of operands/result.
//  EXEC_MUL_EN undefined: those opcodes treated as undefined op (out=0, latency 1); no BUSY state logic synthesised.
// STRUCTURE
//  exec_pkg: XLEN default, opcode localparams (ALU, branch, jump, LS, MUL groups), state enum, helper is_branch/is_mul.
//  Sub-module mul_iter (start, a, b, signed-mode, done, product[2*XLEN-1:0], abort) instantiated only under EXEC_MUL_EN.
//  Top: combinational result/target compute -> output register + 3-state FSM.
// TESTING
//  ADD a=7 b=0xFFFFFFFF accepted N -> out_valid N+1, out_data=6, tag echoed, jump_ena=0.
//  SRA a=0x80000000 b=33 -> 0xC0000000 (shamt=1); SLTU a=1 b=0xFFFFFFFF -> 1; SLT same -> 0.
//  BEQ a=b pc=0x100 imm=-8 -> jump_ena=1, jump_addr=0xF8, out=1; BNE same -> jump_ena=0.
//  JALR a=0x201 imm=2 pc=0x40 -> out=0x44, jump_addr=0x202; out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
//  RESULT pending + flush + in_valid same cycle -> out_valid=0 next cycle, input dropped, in_ready=1.
//  EXEC_MUL_EN: MULH a=-2 b=3 -> out=0xFFFFFFFF at accept+33; flush at accept+10 -> no result, IDLE; reset mid-BUSY -> all outputs 0.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the integer execution unit.
//   - XLEN_DEF / OPC_W : default data width and opcode width
//   - OP_*             : opcode values (ALU, ALU-immediate, upper/jump, branch, load/store, multiply)
//   - state_t          : execution unit FSM states
//   - is_branch/is_ls/is_mul : opcode group helpers
package exec_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned OPC_W    = 6;

  typedef logic [OPC_W-1:0] opc_t;

  // Register-register ALU
  localparam opc_t OP_ADD    = 6'd0;
  localparam opc_t OP_SUB    = 6'd1;
  localparam opc_t OP_AND    = 6'd2;
  localparam opc_t OP_OR     = 6'd3;
  localparam opc_t OP_XOR    = 6'd4;
  localparam opc_t OP_SLL    = 6'd5;
  localparam opc_t OP_SRL    = 6'd6;
  localparam opc_t OP_SRA    = 6'd7;
  localparam opc_t OP_SLT    = 6'd8;
  localparam opc_t OP_SLTU   = 6'd9;
  // Register-immediate ALU
  localparam opc_t OP_ADDI   = 6'd10;
  localparam opc_t OP_ANDI   = 6'd11;
  localparam opc_t OP_ORI    = 6'd12;
  localparam opc_t OP_XORI   = 6'd13;
  localparam opc_t OP_SLLI   = 6'd14;
  localparam opc_t OP_SRLI   = 6'd15;
  localparam opc_t OP_SRAI   = 6'd16;
  localparam opc_t OP_SLTI   = 6'd17;
  localparam opc_t OP_SLTIU  = 6'd18;
  // Upper immediates and jumps
  localparam opc_t OP_LUI    = 6'd19;
  localparam opc_t OP_AUIPC  = 6'd20;
  localparam opc_t OP_JAL    = 6'd21;
  localparam opc_t OP_JALR   = 6'd22;
  // Branches
  localparam opc_t OP_BEQ    = 6'd23;
  localparam opc_t OP_BNE    = 6'd24;
  localparam opc_t OP_BLT    = 6'd25;
  localparam opc_t OP_BGE    = 6'd26;
  localparam opc_t OP_BLTU   = 6'd27;
  localparam opc_t OP_BGEU   = 6'd28;
  // Loads / stores (address generation only)
  localparam opc_t OP_LB     = 6'd29;
  localparam opc_t OP_LH     = 6'd30;
  localparam opc_t OP_LW     = 6'd31;
  localparam opc_t OP_LBU    = 6'd32;
  localparam opc_t OP_LHU    = 6'd33;
  localparam opc_t OP_SB     = 6'd34;
  localparam opc_t OP_SH     = 6'd35;
  localparam opc_t OP_SW     = 6'd36;
  // Multiply
  localparam opc_t OP_MUL    = 6'd37;
  localparam opc_t OP_MULH   = 6'd38;
  localparam opc_t OP_MULHSU = 6'd39;
  localparam opc_t OP_MULHU  = 6'd40;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  function automatic logic is_branch(input opc_t o);
    return (o >= OP_BEQ) && (o <= OP_BGEU);
  endfunction

  function automatic logic is_ls(input opc_t o);
    return (o >= OP_LB) && (o <= OP_SW);
  endfunction

  function automatic logic is_mul(input opc_t o);
    return (o >= OP_MUL) && (o <= OP_MULHU);
  endfunction

endpackage

// File: rtl/exec_unit_mul.sv
// mul_iter: radix-2 shift-add multiplier, one partial product per cycle, XLEN cycles.
// Signed forms are handled by multiplying magnitudes and negating the product.
// Ports:
//   clk, rst            clock, async active-high reset
//   i_start             load operands and begin (ignored while i_abort)
//   i_abort             drop any multiplication in progress
//   i_a, i_b            operands
//   i_a_signed/b_signed treat the matching operand as two's complement
//   o_done              high in the final iteration cycle
//   o_product           full 2*XLEN product, valid while o_done
module mul_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  input  logic              i_a_signed,
  input  logic              i_b_signed,
  output logic              o_done,
  output logic [2*XLEN-1:0] o_product
);

  localparam int unsigned CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic              r_busy;
  logic              r_neg;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_mcand;
  logic [2*XLEN-1:0] r_acc;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_next;

  assign w_a_neg = i_a_signed & i_a[XLEN-1];
  assign w_b_neg = i_b_signed & i_b[XLEN-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // r_acc = {partial high, remaining multiplier bits}; add then shift right.
  assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_next = {w_sum, r_acc[XLEN-1:1]};

  // Product exposed combinationally in the last step so the caller can
  // register it on the same edge that finishes the iteration.
  assign o_done    = r_busy & (r_cnt == LAST);
  assign o_product = r_neg ? -w_next : w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_neg   <= w_a_neg ^ w_b_neg;
      r_cnt   <= '0;
      r_mcand <= w_a_mag;
      r_acc   <= {{XLEN{1'b0}}, w_b_mag};
    end else if (r_busy) begin
      r_acc <= w_next;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: registered integer execution unit between the reservation station
// and the CDB / ROB jump path. One result register, held until out_ready.
// Optional iterative multiplier enabled by defining EXEC_MUL_EN.
// Ports:
//   clk, rst                  clock, async active-high reset
//   flush                     kills accepted and pending work, drops same-cycle input
//   in_valid / in_ready       issue handshake
//   op, in_rob_tag, pc, a, b, imm   issued operation and operands
//   out_valid / out_ready     CDB handshake
//   out_data                  result, load/store address or branch-taken flag
//   out_rob_tag, out_ls_data  result tag, store data (b at issue)
//   jump_ena, jump_addr       redirect request, forced 0 while out_valid=0
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned OP_W  = OPC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [TAG_W-1:0] in_rob_tag,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [XLEN-1:0]  imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_rob_tag,
  output logic [XLEN-1:0]  out_ls_data,
  output logic             jump_ena,
  output logic [XLEN-1:0]  jump_addr
);

  localparam int unsigned SW = $clog2(XLEN);

  state_t r_state, w_next;

  logic [XLEN-1:0]  r_data, r_ls, r_jaddr;
  logic [TAG_W-1:0] r_tag;
  logic             r_jena;

  opc_t             w_op;
  logic             w_accept, w_go_busy, w_mul_store, w_taken, w_jena;
  logic [SW-1:0]    w_shb, w_shi;
  logic [XLEN-1:0]  w_pc4, w_pc_imm, w_a_imm, w_res, w_jaddr;

  assign w_op     = OPC_W'(op);
  assign w_shb    = b[SW-1:0];
  assign w_shi    = imm[SW-1:0];
  assign w_pc4    = pc + XLEN'(4);
  assign w_pc_imm = pc + imm;
  assign w_a_imm  = a + imm;

  assign in_ready  = ~rst & ((r_state == S_IDLE) | ((r_state == S_RESULT) & out_ready));
  assign w_accept  = in_valid & in_ready & ~flush;
  assign out_valid = (r_state == S_RESULT);
  assign out_data    = r_data;
  assign out_rob_tag = r_tag;
  assign out_ls_data = r_ls;
  assign jump_ena  = out_valid & r_jena;
  assign jump_addr = out_valid ? r_jaddr : '0;

  always_comb begin
    case (w_op)
      OP_BEQ:  w_taken = (a == b);
      OP_BNE:  w_taken = (a != b);
      OP_BLT:  w_taken = ($signed(a) < $signed(b));
      OP_BGE:  w_taken = ($signed(a) >= $signed(b));
      OP_BLTU: w_taken = (a < b);
      OP_BGEU: w_taken = (a >= b);
      default: w_taken = 1'b0;
    endcase
  end

  // Multiply opcodes fall to the default arm: 0 when the multiplier is absent,
  // replaced by the product at completion when present.
  always_comb begin
    w_res   = '0;
    w_jena  = 1'b0;
    w_jaddr = '0;
    if (is_branch(w_op)) begin
      w_res   = XLEN'(w_taken);
      w_jena  = w_taken;
      w_jaddr = w_taken ? w_pc_imm : w_pc4;
    end else if (is_ls(w_op)) begin
      w_res = w_a_imm;
    end else begin
      case (w_op)
        OP_ADD:   w_res = a + b;
        OP_SUB:   w_res = a - b;
        OP_AND:   w_res = a & b;
        OP_OR:    w_res = a | b;
        OP_XOR:   w_res = a ^ b;
        OP_SLL:   w_res = a << w_shb;
        OP_SRL:   w_res = a >> w_shb;
        OP_SRA:   w_res = $signed(a) >>> w_shb;
        OP_SLT:   w_res = XLEN'($signed(a) < $signed(b));
        OP_SLTU:  w_res = XLEN'(a < b);
        OP_ADDI:  w_res = w_a_imm;
        OP_ANDI:  w_res = a & imm;
        OP_ORI:   w_res = a | imm;
        OP_XORI:  w_res = a ^ imm;
        OP_SLLI:  w_res = a << w_shi;
        OP_SRLI:  w_res = a >> w_shi;
        OP_SRAI:  w_res = $signed(a) >>> w_shi;
        OP_SLTI:  w_res = XLEN'($signed(a) < $signed(imm));
        OP_SLTIU: w_res = XLEN'(a < imm);
        OP_LUI:   w_res = imm;
        OP_AUIPC: w_res = w_pc_imm;
        OP_JAL:   w_res = w_pc4;
        OP_JALR: begin
          w_res   = w_pc4;
          w_jena  = 1'b1;
          w_jaddr = {w_a_imm[XLEN-1:1], 1'b0};
        end
        default:  w_res = '0;
      endcase
    end
  end

`ifdef EXEC_MUL_EN
  logic              w_mul_done;
  logic              r_mul_hi;
  logic [2*XLEN-1:0] w_product;

  assign w_go_busy = w_accept & is_mul(w_op);

  mul_iter #(.XLEN(XLEN)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_go_busy),
    .i_abort    (flush),
    .i_a        (a),
    .i_b        (b),
    .i_a_signed ((w_op == OP_MULH) | (w_op == OP_MULHSU)),
    .i_b_signed (w_op == OP_MULH),
    .o_done     (w_mul_done),
    .o_product  (w_product)
  );
`else
  assign w_go_busy = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_mul_store = 1'b0;
    case (r_state)
      S_IDLE, S_RESULT: begin
        if (w_accept)                               w_next = w_go_busy ? S_BUSY : S_RESULT;
        else if ((r_state == S_RESULT) && out_ready) w_next = S_IDLE;
      end
`ifdef EXEC_MUL_EN
      S_BUSY: begin
        if (w_mul_done) begin
          w_next      = S_RESULT;
          w_mul_store = 1'b1;
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
    if (flush) begin
      w_next      = S_IDLE;
      w_mul_store = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_tag   <= '0;
      r_ls    <= '0;
      r_jena  <= 1'b0;
      r_jaddr <= '0;
`ifdef EXEC_MUL_EN
      r_mul_hi <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_data  <= w_res;
        r_tag   <= in_rob_tag;
        r_ls    <= b;
        r_jena  <= w_jena;
        r_jaddr <= w_jaddr;
      end
`ifdef EXEC_MUL_EN
      if (w_accept) r_mul_hi <= (w_op != OP_MUL);
      if (w_mul_store) r_data <= r_mul_hi ? w_product[2*XLEN-1:XLEN] : w_product[XLEN-1:0];
`endif
    end
  end

endmodule
